dcache: RTL
===========

# dcache

Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the ALU in the single-cycle CPU. The ALU RESULT drives ADDRESS, and the register file supplies WRITEDATA. The cache answers hits with no stall. On a miss it stalls the CPU through BUSYWAIT while a state machine runs a block write-back and/or fetch against the 32-bit-wide data memory.

## Interface
- Parameters:
  - ADDR_W, 8: CPU byte-address width.
  - NUM_BLOCKS, 8: number of cache lines.
  - BLOCK_BYTES, 4: bytes per line.
- Ports:
  - CLK  input  1  system clock; all state updates on rising edge.
  - RESET  input  1  asynchronous, active-high reset.
  - READ  input  1  CPU load request.
  - WRITE  input  1  CPU store request.
  - ADDRESS  input  8  byte address: tag[7:5], index[4:2], offset[1:0].
  - WRITEDATA  input  8  store data.
  - READDATA  output  8  load data.
  - BUSYWAIT  output  1  CPU stall.
  - MEM_READ  output  1  memory block-read strobe.
  - MEM_WRITE  output  1  memory block-write strobe.
  - MEM_ADDRESS  output  6  block address {tag,index}.
  - MEM_WRITEDATA  output  32  write-back block; byte 0 is in [7:0].
  - MEM_READDATA  input  32  fetched block.
  - MEM_BUSYWAIT  input  1  memory busy.
  - HIT_COUNT  output  16  hit counter (see Configuration).
  - MISS_COUNT  output  16  miss counter (see Configuration).

## Operation
- Per line: valid, dirty, 3-bit tag, 32-bit data. hit = valid[index] & (tag[index]==ADDRESS[7:5]).
- Request = READ|WRITE.
  - READ and WRITE both high is illegal; the cache treats it as WRITE.
  - The CPU holds the request and its operands stable while BUSYWAIT=1.
- States: IDLE, WRITEBACK, FETCH.
- IDLE:
  - No request: BUSYWAIT=0, no state change.
  - Read hit: READDATA = byte[offset] of the indexed line, BUSYWAIT=0.
  - Write hit: at the clock edge, byte[offset] ← WRITEDATA and dirty ← 1; BUSYWAIT=0.
  - Miss on a clean or invalid line: → FETCH.
  - Miss on a dirty line: → WRITEBACK.
- WRITEBACK:
  - Drives MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data.
  - On completion → FETCH.
- FETCH:
  - Drives MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}.
  - On completion: line data ← MEM_READDATA, tag updated, valid=1, dirty=0, → IDLE.
  - The next IDLE cycle then hits and serves the original request.
- READDATA = 0x00 whenever there is no read hit in IDLE.
- MEM_* outputs are 0 in IDLE.

## Timing
- Reset, taking effect immediately:
  - State IDLE; all valid and dirty bits cleared.
  - BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0, counters=0.
  - Reset during WRITEBACK or FETCH abandons the transaction; the strobe drops asynchronously and the dirty data is lost by design.
- BUSYWAIT:
  - Combinational; equals request & ~hit in IDLE, and 1 in WRITEBACK and FETCH.
  - A miss raises BUSYWAIT in the same cycle as the request.
- Memory handshake:
  - Memory raises MEM_BUSYWAIT no later than the cycle after a strobe rises.
  - Completion = first rising edge, at least one cycle after entering the state, that samples MEM_BUSYWAIT=0.
  - Each strobe stays high continuously until completion.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: fetch duration + 1 cycle.
  - Dirty miss: write-back duration + fetch duration + 1 cycle.
- An address change while in IDLE re-evaluates hit in the same cycle; no stale-hit hold.

## Configuration
- DCACHE_STATS_EN defined:
  - HIT_COUNT increments once per request served by an IDLE hit.
  - MISS_COUNT increments once per IDLE→(WRITEBACK|FETCH) transition.
  - The post-fill hit cycle is not counted as a hit.
  - Both counters saturate at 0xFFFF.
- DCACHE_STATS_EN undefined: HIT_COUNT and MISS_COUNT are tied to 0 and no counter logic is built.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, FETCH);
  - tag, index and offset widths and field positions;
  - block width (32) and the counter width (16).
- One sub-module, dcache_array: valid, dirty, tag and data storage.
  - Provides a synchronous fill port and a synchronous byte-write port.
  - Provides a combinational read of the indexed line.
- The FSM, hit logic and counters stay in dcache.

## Test plan
- After reset, READ 0x14:
  - BUSYWAIT=1; MEM_READ=1 with MEM_ADDRESS=0x05.
  - Memory returns 0xDDCCBBAA after 5 cycles busy.
  - Cache returns to IDLE, then READDATA=0xAA and BUSYWAIT=0.
- After that fill, WRITE 0x15 with data 0x5A:
  - No stall; the line is marked dirty.
  - A following READ 0x15 gives READDATA=0x5A in the same cycle.
- Then READ 0x34:
  - WRITEBACK with MEM_ADDRESS=0x05 and MEM_WRITEDATA=0xDDCC5AAA.
  - Then FETCH with MEM_ADDRESS=0x0D; BUSYWAIT stays high throughout both phases.
- RESET pulsed on the 2nd FETCH cycle:
  - MEM_READ and BUSYWAIT drop without waiting for CLK.
  - A subsequent READ 0x14 misses again (valid was cleared).
- READ=WRITE=0 with MEM_BUSYWAIT toggling: BUSYWAIT=0, MEM strobes stay 0, no line changes.
- With DCACHE_STATS_EN, run the sequence above (without the reset): HIT_COUNT=2 and MISS_COUNT=2. Without the macro, both counters read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, state encoding and byte-select helper for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int BYTE_W     = 8;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = 3;
  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_W;
  localparam int MADDR_W    = TAG_W + INDEX_W;
  localparam int BLOCK_W    = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  // Select byte 'off' of a block; byte 0 lives in bits [7:0].
  function automatic logic [BYTE_W-1:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-line valid/dirty/tag/data storage with a combinational
// read of the indexed line, a synchronous fill port and a synchronous
// byte-write port. Fill has priority over byte write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data,
  input  logic               wr_en,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [BYTE_W-1:0]  wr_data,
  output logic               line_valid,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLOCK_W-1:0] line_data
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  // Status bits: cleared by reset, set valid/clean on fill, dirty on store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (wr_en) begin
      data_q[index][{wr_offset, 3'b000} +: BYTE_W] <= wr_data;
    end
  end

  assign line_valid = valid_q[index];
  assign line_dirty = dirty_q[index];
  assign line_tag   = tag_q[index];
  assign line_data  = data_q[index];

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
// Hits are served combinationally; misses stall the CPU via BUSYWAIT while
// the FSM writes back a dirty victim and/or fetches the missing block.
// Optional feature macro: DCACHE_STATS_EN builds saturating hit/miss counters;
// without it HIT_COUNT and MISS_COUNT are tied to zero.
//
// Memory handshake: a strobe (MEM_READ / MEM_WRITE) is held high for the
// whole WRITEBACK / FETCH state; the transfer completes at the first rising
// edge after the state's first cycle that samples MEM_BUSYWAIT=0. The first
// edge is ignored because memory may only raise MEM_BUSYWAIT a cycle late.
module dcache
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [BYTE_W-1:0]          WRITEDATA,
  output logic [BYTE_W-1:0]          READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [MADDR_W-1:0]         MEM_ADDRESS,
  output logic [8*BLOCK_BYTES-1:0]   MEM_WRITEDATA,
  input  logic [8*BLOCK_BYTES-1:0]   MEM_READDATA,
  input  logic                       MEM_BUSYWAIT,
  output logic [CNT_W-1:0]           HIT_COUNT,
  output logic [CNT_W-1:0]           MISS_COUNT
);

  state_t state;
  state_t state_next;
  logic   armed;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic                req;
  logic                hit;
  logic                mem_done;
  logic                fill_en;
  logic                wr_en;

  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;

  assign addr_tag    = ADDRESS[TAG_LSB +: TAG_W];
  assign addr_index  = ADDRESS[INDEX_LSB +: INDEX_W];
  assign addr_offset = ADDRESS[OFFSET_LSB +: OFFSET_W];

  assign req      = READ | WRITE;
  assign hit      = line_valid & (line_tag == addr_tag);
  assign mem_done = armed & ~MEM_BUSYWAIT;
  assign fill_en  = (state == FETCH) & mem_done;
  assign wr_en    = (state == IDLE) & WRITE & hit;

  dcache_array #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_array (
    .clk        (CLK),
    .rst        (RESET),
    .index      (addr_index),
    .fill_en    (fill_en),
    .fill_tag   (addr_tag),
    .fill_data  (MEM_READDATA),
    .wr_en      (wr_en),
    .wr_offset  (addr_offset),
    .wr_data    (WRITEDATA),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data)
  );

  // State register; armed goes high after the first cycle spent in a memory state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= (state != IDLE) && (state_next == state);
    end
  end

  // Next-state: misses leave IDLE, memory completion advances the transfer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          state_next = (line_valid && line_dirty) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: if (mem_done) state_next = FETCH;
      FETCH:     if (mem_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs: CPU stall, read data and memory strobes; all forced low in reset.
  always_comb begin
    READDATA      = '0;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    unique case (state)
      IDLE: begin
        BUSYWAIT = req & ~hit;
        if (READ && !WRITE && hit) READDATA = get_byte(line_data, addr_offset);
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {line_tag, addr_index};
        MEM_WRITEDATA = line_data;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_index};
      end
      default: ;
    endcase
    if (RESET) begin
      READDATA      = '0;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic             just_filled;
  logic             hit_inc;
  logic             miss_inc;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  // The IDLE cycle right after a fill finishes a miss, so it is not a hit.
  assign hit_inc  = (state == IDLE) & req & hit & ~just_filled;
  assign miss_inc = (state == IDLE) & req & ~hit;

  // Saturating hit/miss counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      just_filled <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      just_filled <= fill_en;
      if (hit_inc && (hit_q != '1))   hit_q  <= hit_q + 1'b1;
      if (miss_inc && (miss_q != '1)) miss_q <= miss_q + 1'b1;
    end
  end

  assign HIT_COUNT  = hit_q;
  assign MISS_COUNT = miss_q;
`else
  assign HIT_COUNT  = '0;
  assign MISS_COUNT = '0;
`endif

endmodule
